// File: rtl/csr_sayac_birimi.sv
// Machine counter CSR unit: mcycle, minstret, mhpmcounterN/mhpmeventN and mcountinhibit.
// Define SAYAC_TASMA_KESME_EN for sticky overflow flags in mhpmeventN[31] driving tasma_kesme_o.
module csr_sayac_birimi #(
  parameter int unsigned SAYAC_SAYISI   = 4,
  parameter int unsigned SAYAC_GENISLIK = 64,
  parameter int unsigned OLAY_SAYISI    = 8
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   istek_gecerli_i,
  output logic                   istek_hazir_o,
  input  logic [11:0]            istek_adres_i,
  input  logic [1:0]             istek_islem_i,
  input  logic [31:0]            istek_veri_i,
  output logic                   yanit_gecerli_o,
  input  logic                   yanit_hazir_i,
  output logic [31:0]            yanit_veri_o,
  output logic                   yanit_hata_o,
  input  logic [1:0]             emekli_sayi_i,
  input  logic [OLAY_SAYISI-1:0] olay_i,
  output logic                   tasma_kesme_o
);

  localparam int unsigned W  = SAYAC_GENISLIK;
  localparam int unsigned NH = (SAYAC_SAYISI == 0) ? 1 : SAYAC_SAYISI;

  localparam logic [1:0] OpRw = 2'b01;
  localparam logic [1:0] OpRs = 2'b10;
  localparam logic [1:0] OpRc = 2'b11;

  function automatic logic [31:0] inh_mask_f();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < int'(SAYAC_SAYISI); i++) m[3+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] InhMask = inh_mask_f();

  function automatic logic [63:0] ext64(input logic [W-1:0] v);
    logic [63:0] e;
    e = '0;
    e[W-1:0] = v;
    return e;
  endfunction

  // Increment first, then the written half overrides; the other half keeps the carry.
  function automatic logic [W-1:0] cnt_next(input logic [W-1:0] old, input logic [W-1:0] inc,
                                            input logic wr_lo, input logic wr_hi,
                                            input logic [31:0] wd);
    logic [63:0] t;
    t = ext64(old + inc);
    if (wr_lo) t[31:0] = wd;
    if (wr_hi) t[63:32] = wd;
    return t[W-1:0];
  endfunction

  // State
  logic [W-1:0]  mcycle_q, mcycle_d;
  logic [W-1:0]  minstret_q, minstret_d;
  logic [W-1:0]  hpm_q [NH];
  logic [W-1:0]  hpm_d [NH];
  logic [30:0]   evt_q [NH];
  logic [30:0]   evt_d [NH];
  logic [31:0]   inh_q, inh_d;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_data_q;
`ifdef SAYAC_TASMA_KESME_EN
  logic [NH-1:0] of_q, of_d;
  logic          irq_q;
`endif

  // Decode and read path
  logic          sel_cy_lo, sel_cy_hi, sel_ir_lo, sel_ir_hi, sel_inh;
  logic [NH-1:0] sel_hpm_lo, sel_hpm_hi, sel_evt;
  logic          hit;
  logic [31:0]   rd_val, wr_val;
  logic [63:0]   cy_ext, ir_ext;
  logic [63:0]   hpm_ext [NH];
  logic [31:0]   evt_rd [NH];
  logic          accept, wr_en;
  logic          cy_inc;
  logic [1:0]    ir_inc;
  logic [NH-1:0] hpm_inc;

  always_comb begin
    cy_ext = ext64(mcycle_q);
    ir_ext = ext64(minstret_q);
    for (int i = 0; i < int'(NH); i++) begin
      hpm_ext[i] = ext64(hpm_q[i]);
`ifdef SAYAC_TASMA_KESME_EN
      evt_rd[i] = {of_q[i], evt_q[i]};
`else
      evt_rd[i] = {1'b0, evt_q[i]};
`endif
    end
  end

  always_comb begin
    sel_cy_lo  = (istek_adres_i == 12'hB00);
    sel_cy_hi  = (istek_adres_i == 12'hB80);
    sel_ir_lo  = (istek_adres_i == 12'hB02);
    sel_ir_hi  = (istek_adres_i == 12'hB82);
    sel_inh    = (istek_adres_i == 12'h320);
    sel_hpm_lo = '0;
    sel_hpm_hi = '0;
    sel_evt    = '0;
    for (int i = 0; i < int'(SAYAC_SAYISI); i++) begin
      sel_hpm_lo[i] = (istek_adres_i == 12'hB03 + 12'(i));
      sel_hpm_hi[i] = (istek_adres_i == 12'hB83 + 12'(i));
      sel_evt[i]    = (istek_adres_i == 12'h323 + 12'(i));
    end
    hit = sel_cy_lo | sel_cy_hi | sel_ir_lo | sel_ir_hi | sel_inh |
          (|sel_hpm_lo) | (|sel_hpm_hi) | (|sel_evt);
    rd_val = ({32{sel_cy_lo}} & cy_ext[31:0])  | ({32{sel_cy_hi}} & cy_ext[63:32]) |
             ({32{sel_ir_lo}} & ir_ext[31:0])  | ({32{sel_ir_hi}} & ir_ext[63:32]) |
             ({32{sel_inh}}   & inh_q);
    for (int i = 0; i < int'(NH); i++) begin
      rd_val = rd_val | ({32{sel_hpm_lo[i]}} & hpm_ext[i][31:0]) |
               ({32{sel_hpm_hi[i]}} & hpm_ext[i][63:32]) | ({32{sel_evt[i]}} & evt_rd[i]);
    end
  end

  always_comb begin
    case (istek_islem_i)
      OpRw:    wr_val = istek_veri_i;
      OpRs:    wr_val = rd_val | istek_veri_i;
      OpRc:    wr_val = rd_val & ~istek_veri_i;
      default: wr_val = rd_val;
    endcase
  end

  assign accept = istek_gecerli_i & ~resp_valid_q;
  // RS/RC with a zero operand is a pure read and must not write.
  assign wr_en  = accept & hit &
                  ((istek_islem_i == OpRw) | (istek_islem_i[1] & (|istek_veri_i)));

  // Counting enables
  always_comb begin
    cy_inc  = ~inh_q[0];
    ir_inc  = inh_q[2] ? 2'd0 : emekli_sayi_i;
    hpm_inc = '0;
    for (int i = 0; i < int'(SAYAC_SAYISI); i++) begin
      for (int k = 1; k <= int'(OLAY_SAYISI); k++) begin
        if ((evt_q[i] == 31'(k)) && olay_i[k-1]) hpm_inc[i] = 1'b1;
      end
      if (inh_q[3+i]) hpm_inc[i] = 1'b0;
    end
  end

  // Next state
  always_comb begin
    mcycle_d   = cnt_next(mcycle_q, W'(cy_inc), wr_en & sel_cy_lo, wr_en & sel_cy_hi, wr_val);
    minstret_d = cnt_next(minstret_q, W'(ir_inc), wr_en & sel_ir_lo, wr_en & sel_ir_hi, wr_val);
    inh_d      = (wr_en & sel_inh) ? (wr_val & InhMask) : inh_q;
    for (int i = 0; i < int'(NH); i++) begin
      hpm_d[i] = cnt_next(hpm_q[i], W'(hpm_inc[i]), wr_en & sel_hpm_lo[i],
                          wr_en & sel_hpm_hi[i], wr_val);
      evt_d[i] = (wr_en & sel_evt[i]) ? wr_val[30:0] : evt_q[i];
`ifdef SAYAC_TASMA_KESME_EN
      of_d[i]  = (wr_en & sel_evt[i]) ? wr_val[31] : of_q[i];
      // A wrap in the same cycle as a clearing write still sets the flag.
      if (hpm_inc[i] && (hpm_q[i] == {W{1'b1}})) of_d[i] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mcycle_q     <= '0;
      minstret_q   <= '0;
      inh_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      for (int i = 0; i < int'(NH); i++) begin
        hpm_q[i] <= '0;
        evt_q[i] <= '0;
      end
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inh_q      <= inh_d;
      for (int i = 0; i < int'(NH); i++) begin
        hpm_q[i] <= hpm_d[i];
        evt_q[i] <= evt_d[i];
      end
      if (accept) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= rd_val;
        resp_err_q   <= ~hit;
      end else if (yanit_hazir_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

`ifdef SAYAC_TASMA_KESME_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      of_q  <= '0;
      irq_q <= 1'b0;
    end else begin
      of_q  <= of_d;
      irq_q <= |of_q;
    end
  end

  assign tasma_kesme_o = irq_q;
`else
  assign tasma_kesme_o = 1'b0;
`endif

  assign istek_hazir_o   = ~resp_valid_q;
  assign yanit_gecerli_o = resp_valid_q;
  assign yanit_veri_o    = resp_data_q;
  assign yanit_hata_o    = resp_err_q;

endmodule

// File: tb/tb_csr_sayac_birimi.sv
// Directed bench for csr_sayac_birimi with hand-computed expected CSR values.
// Overflow-interrupt checks are compiled when SAYAC_TASMA_KESME_EN is defined.
module tb_csr_sayac_birimi;

  localparam int unsigned NO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          istek_gecerli;
  logic          istek_hazir;
  logic [11:0]   istek_adres;
  logic [1:0]    istek_islem;
  logic [31:0]   istek_veri;
  logic          yanit_gecerli;
  logic          yanit_hazir;
  logic [31:0]   yanit_veri;
  logic          yanit_hata;
  logic [1:0]    emekli_sayi;
  logic [NO-1:0] olay;
  logic          tasma_kesme;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_sayac_birimi #(
    .SAYAC_SAYISI  (4),
    .SAYAC_GENISLIK(64),
    .OLAY_SAYISI   (NO)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .istek_gecerli_i(istek_gecerli),
    .istek_hazir_o  (istek_hazir),
    .istek_adres_i  (istek_adres),
    .istek_islem_i  (istek_islem),
    .istek_veri_i   (istek_veri),
    .yanit_gecerli_o(yanit_gecerli),
    .yanit_hazir_i  (yanit_hazir),
    .yanit_veri_o   (yanit_veri),
    .yanit_hata_o   (yanit_hata),
    .emekli_sayi_i  (emekli_sayi),
    .olay_i         (olay),
    .tasma_kesme_o  (tasma_kesme)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with no response pending; returns at the negedge after consumption.
  task automatic csr_op(input logic [1:0] op, input logic [11:0] adr, input logic [31:0] d,
                        input logic [NO-1:0] ev, output logic [31:0] q, output logic e);
    check("req_hazir", 32'(istek_hazir), 32'd1);
    istek_gecerli = 1'b1;
    istek_islem   = op;
    istek_adres   = adr;
    istek_veri    = d;
    olay          = ev;
    @(posedge clk);
    @(negedge clk);
    istek_gecerli = 1'b0;
    olay          = '0;
    check("rsp_gecerli", 32'(yanit_gecerli), 32'd1);
    q = yanit_veri;
    e = yanit_hata;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, q2;
    logic        e;

    rstn          = 1'b0;
    istek_gecerli = 1'b0;
    istek_adres   = '0;
    istek_islem   = '0;
    istek_veri    = '0;
    yanit_hazir   = 1'b1;
    emekli_sayi   = 2'd0;
    olay          = '0;
    repeat (3) @(negedge clk);
    check("rst_gecerli", 32'(yanit_gecerli), 32'd0);
    check("rst_veri", yanit_veri, 32'd0);
    check("rst_hata", 32'(yanit_hata), 32'd0);
    check("rst_tasma", 32'(tasma_kesme), 32'd0);
    check("rst_hazir", 32'(istek_hazir), 32'd1);
    rstn = 1'b1;
    @(negedge clk);

    // mcycle advances by the distance between acceptance edges
    csr_op(2'b00, 12'hB00, 32'd0, '0, q, e);
    check("cy_rd1_hata", 32'(e), 32'd0);
    csr_op(2'b00, 12'hB00, 32'd0, '0, q2, e);
    check("cy_rd2_delta", q2, q + 32'd2);
    check("cy_rd2_hata", 32'(e), 32'd0);
    csr_op(2'b00, 12'h320, 32'd0, '0, q, e);
    check("inh_rst", q, 32'd0);
    csr_op(2'b00, 12'h323, 32'd0, '0, q, e);
    check("evt3_rst", q, 32'd0);

    // Inhibit CY and IR; minstret and mcycle freeze
    csr_op(2'b01, 12'h320, 32'h5, '0, q, e);
    check("inh_old", q, 32'd0);
    emekli_sayi = 2'd2;
    csr_op(2'b01, 12'hB02, 32'hFFFF_FFFF, '0, q, e);
    check("ir_old_zero", q, 32'd0);
    csr_op(2'b00, 12'hB02, 32'd0, '0, q, e);
    check("ir_frozen1", q, 32'hFFFF_FFFF);
    csr_op(2'b00, 12'hB02, 32'd0, '0, q, e);
    check("ir_frozen2", q, 32'hFFFF_FFFF);
    csr_op(2'b00, 12'hB00, 32'd0, '0, q, e);
    csr_op(2'b00, 12'hB00, 32'd0, '0, q2, e);
    check("cy_frozen", q2, q);
    emekli_sayi = 2'd0;

    // Masked RS / RC on mcountinhibit
    csr_op(2'b10, 12'h320, 32'hFFFF_FFFF, '0, q, e);
    check("inh_rs_old", q, 32'h5);
    csr_op(2'b00, 12'h320, 32'd0, '0, q, e);
    check("inh_mask", q, 32'h0000_007D);
    csr_op(2'b11, 12'h320, 32'hFFFF_FFF8, '0, q, e);
    check("inh_rc_old", q, 32'h0000_007D);
    csr_op(2'b00, 12'h320, 32'd0, '0, q, e);
    check("inh_after_rc", q, 32'h5);

    // minstret all-ones + 2 wraps to 1
    csr_op(2'b01, 12'hB82, 32'hFFFF_FFFF, '0, q, e);
    csr_op(2'b01, 12'h320, 32'h1, '0, q, e);
    emekli_sayi = 2'd2;
    @(negedge clk);
    emekli_sayi = 2'd0;
    csr_op(2'b00, 12'hB02, 32'd0, '0, q, e);
    check("ir_wrap_lo", q, 32'd1);
    csr_op(2'b00, 12'hB82, 32'd0, '0, q, e);
    check("ir_wrap_hi", q, 32'd0);

    // Event selection: only olay[1] counts for mhpmevent3 = 2
    csr_op(2'b01, 12'h323, 32'd2, '0, q, e);
    for (int i = 0; i < 5; i++) begin
      olay = 8'b0000_0010;
      @(negedge clk);
      olay = 8'b0000_0001;
      @(negedge clk);
    end
    olay = '0;
    csr_op(2'b00, 12'hB03, 32'd0, '0, q, e);
    check("hpm3_cnt", q, 32'd5);
    csr_op(2'b00, 12'hB83, 32'd0, '0, q, e);
    check("hpm3_hi", q, 32'd0);
    csr_op(2'b00, 12'h323, 32'd0, '0, q, e);
    check("evt3_val", q, 32'd2);

    // Write and increment in the same cycle: write wins on the low half
    csr_op(2'b01, 12'hB03, 32'hFFFF_FFFF, 8'b0000_0010, q, e);
    check("hpm3_wr_old", q, 32'd5);
    csr_op(2'b00, 12'hB03, 32'd0, '0, q, e);
    check("hpm3_lo_ones", q, 32'hFFFF_FFFF);
    csr_op(2'b00, 12'hB83, 32'd0, '0, q, e);
    check("hpm3_hi_zero", q, 32'd0);
    olay = 8'b0000_0010;
    @(negedge clk);
    olay = '0;
    csr_op(2'b00, 12'hB83, 32'd0, '0, q, e);
    check("hpm3_hi_carry", q, 32'd1);
    csr_op(2'b00, 12'hB03, 32'd0, '0, q, e);
    check("hpm3_lo_wrap", q, 32'd0);

    // RS with zero operand is a pure read
    csr_op(2'b10, 12'hB83, 32'd0, '0, q, e);
    check("rs0_read", q, 32'd1);

    // Unmapped address with back-pressure
    yanit_hazir   = 1'b0;
    istek_gecerli = 1'b1;
    istek_islem   = 2'b00;
    istek_adres   = 12'h7C0;
    @(posedge clk);
    @(negedge clk);
    istek_gecerli = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("unm_gecerli", 32'(yanit_gecerli), 32'd1);
      check("unm_hata", 32'(yanit_hata), 32'd1);
      check("unm_veri", yanit_veri, 32'd0);
      check("unm_hazir", 32'(istek_hazir), 32'd0);
      @(negedge clk);
    end
    yanit_hazir = 1'b1;
    @(negedge clk);
    check("unm_done", 32'(yanit_gecerli), 32'd0);
    check("unm_hazir_back", 32'(istek_hazir), 32'd1);

`ifdef SAYAC_TASMA_KESME_EN
    csr_op(2'b01, 12'hB03, 32'hFFFF_FFFF, '0, q, e);
    csr_op(2'b01, 12'hB83, 32'hFFFF_FFFF, '0, q, e);
    check("of_pre_tasma", 32'(tasma_kesme), 32'd0);
    olay = 8'b0000_0010;
    @(negedge clk);
    olay = '0;
    @(negedge clk);
    check("of_tasma", 32'(tasma_kesme), 32'd1);
    csr_op(2'b00, 12'h323, 32'd0, '0, q, e);
    check("of_flag", q, 32'h8000_0002);
    csr_op(2'b00, 12'hB03, 32'd0, '0, q, e);
    check("of_cnt_lo", q, 32'd0);
    csr_op(2'b00, 12'hB83, 32'd0, '0, q, e);
    check("of_cnt_hi", q, 32'd0);
`else
    csr_op(2'b01, 12'h323, 32'h8000_0002, '0, q, e);
    csr_op(2'b00, 12'h323, 32'd0, '0, q, e);
    check("evt_bit31_ign", q, 32'd2);
    check("tasma_tied", 32'(tasma_kesme), 32'd0);
`endif

    // Reset while a response is pending
    yanit_hazir   = 1'b0;
    istek_gecerli = 1'b1;
    istek_islem   = 2'b01;
    istek_adres   = 12'hB03;
    istek_veri    = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    istek_gecerli = 1'b0;
    rstn          = 1'b0;
    #1;
    check("mid_rst_gecerli", 32'(yanit_gecerli), 32'd0);
    check("mid_rst_hazir", 32'(istek_hazir), 32'd1);
    check("mid_rst_tasma", 32'(tasma_kesme), 32'd0);
    @(negedge clk);
    rstn        = 1'b1;
    yanit_hazir = 1'b1;
    @(negedge clk);
    csr_op(2'b00, 12'hB03, 32'd0, '0, q, e);
    check("mid_rst_hpm3", q, 32'd0);
    csr_op(2'b00, 12'h320, 32'd0, '0, q, e);
    check("mid_rst_inh", q, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
